// File: rtl/debounce_arbiter.sv
// Debounces N_CH button inputs with one round-robin shared bounce timer and queues
// press/release events in a FWFT FIFO. Define DEBOUNCE_ARB_RELEASE_EN to also queue releases.
module debounce_arbiter #(
    parameter int N_CH        = 4,
    parameter int ID_W        = 2,
    parameter int TIMER_W     = 21,
    parameter int BOUNCE_TIME = 1_250_000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] in,
    output logic [N_CH-1:0] level,
    output logic            busy,
    output logic            ev_valid,
    output logic [ID_W-1:0] ev_id,
    output logic            ev_press,
    input  logic            ev_ready,
    output logic            overflow
);
    // state  | meaning
    // IDLE   | no channel owns the timer; pick the next pending one round-robin
    // COUNT  | granted channel must stay opposite its level for BOUNCE_TIME cycles
    // COMMIT | flip the granted level, push the event, advance the pointer
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [N_CH-1:0]    sync1_q, s_q;
    logic [N_CH-1:0]    level_q;
    state_t             state_q;
    logic [TIMER_W-1:0] timer_q;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic               busy_q;
    logic               overflow_q;

    logic [N_CH-1:0]    pending;
    logic               any_pending;
    logic [ID_W-1:0]    hi_idx, lo_idx;
    logic               found_hi;
    logic               new_lvl;

    logic [ID_W-1:0]    mem_id_q [FIFO_DEPTH];
`ifdef DEBOUNCE_ARB_RELEASE_EN
    logic               mem_press_q [FIFO_DEPTH];
`endif
    logic [AW:0]        wr_ptr_q, rd_ptr_q;
    logic               empty, full, push, pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            s_q     <= '0;
        end else begin
            sync1_q <= in;
            s_q     <= sync1_q;
        end
    end

    assign pending = s_q ^ level_q;

    // Lowest pending index at or above rr wins; otherwise wrap to the lowest pending index.
    always_comb begin
        hi_idx      = '0;
        lo_idx      = '0;
        found_hi    = 1'b0;
        any_pending = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                lo_idx      = ID_W'(i);
                any_pending = 1'b1;
                if (ID_W'(i) >= rr_q) begin
                    hi_idx   = ID_W'(i);
                    found_hi = 1'b1;
                end
            end
        end
        grant_d = found_hi ? hi_idx : lo_idx;
    end

    assign rr_d    = (grant_q == ID_W'(N_CH - 1)) ? '0 : grant_q + ID_W'(1);
    assign new_lvl = ~level_q[grant_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            grant_q <= '0;
            rr_q    <= '0;
            level_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_pending) begin
                        grant_q <= grant_d;
                        timer_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= COUNT;
                    end
                end
                COUNT: begin
                    if (s_q[grant_q] == level_q[grant_q]) begin
                        rr_q    <= rr_d;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (timer_q == TIMER_W'(BOUNCE_TIME - 1)) begin
                        state_q <= COMMIT;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                COMMIT: begin
                    level_q[grant_q] <= new_lvl;
                    rr_q             <= rr_d;
                    busy_q           <= 1'b0;
                    state_q          <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef DEBOUNCE_ARB_RELEASE_EN
    assign push = (state_q == COMMIT);
`else
    assign push = (state_q == COMMIT) && new_lvl;
`endif

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && ev_ready;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is only dropped without one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_id_q[i] <= '0;
`ifdef DEBOUNCE_ARB_RELEASE_EN
                mem_press_q[i] <= 1'b0;
`endif
            end
        end else begin
            overflow_q <= push && full && !pop;
            if (push && (!full || pop)) begin
                mem_id_q[wr_ptr_q[AW-1:0]] <= grant_q;
`ifdef DEBOUNCE_ARB_RELEASE_EN
                mem_press_q[wr_ptr_q[AW-1:0]] <= new_lvl;
`endif
                wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
            end
        end
    end

    assign level    = level_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;
    assign ev_valid = !empty;
    assign ev_id    = mem_id_q[rd_ptr_q[AW-1:0]];
`ifdef DEBOUNCE_ARB_RELEASE_EN
    assign ev_press = mem_press_q[rd_ptr_q[AW-1:0]];
`else
    assign ev_press = 1'b1;
`endif

endmodule
